mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store sequencer between the CPU execute stage and the 32-bit word RAM. It accepts one byte/halfword/word request at a time and drives the RAM's rdEn/wrEn/addr and shared tri-state data bus. It performs read-modify-write for sub-word stores and aligns and extends load data. Misaligned and out-of-range accesses return an error without touching memory.

Parameters:
DWIDTH, 32, data and address width
MEM_BYTES, 256, addressable bytes; any req_addr >= MEM_BYTES is out of range

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle and able to accept
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  loads only: sign-extend (1) or zero-extend (0)
req_addr  input  DWIDTH  byte address
req_wdata  input  DWIDTH  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DWIDTH  aligned/extended load data; 0 for stores and errors
resp_err  output  1  qualifies resp_valid: misaligned, illegal size, or out of range
mem_addr  output  DWIDTH  RAM word address = request address with [1:0] forced to 0
mem_rdEn  output  1  RAM read enable
mem_wrEn  output  1  RAM write enable
mem_data  inout  DWIDTH  shared RAM data bus

Behaviour:
- States: IDLE, RD1, RD2, WR, RESP, ERR. req_ready=1 only in IDLE. Accept on posedge with req_valid&&req_ready.
- Request fields are registered on accept. Inputs are ignored outside IDLE.
- Error check at accept: size==11; half with addr[0]; word with addr[1:0]!=0; addr>=MEM_BYTES.
  - An error goes IDLE->ERR.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, no mem enables, then back to IDLE.
- Load: IDLE->RD1->RD2->RESP->IDLE.
  - mem_rdEn=1 in RD1 and RD2.
  - RAM latches its word at the end of RD1 and drives the bus during RD2. The unit captures mem_data at the end of RD2.
  - resp_valid is asserted in the 3rd cycle after the accept edge.
- Word store: IDLE->WR->RESP. In WR, mem_wrEn=1 and the unit drives mem_data = req_wdata.
- Sub-word store: IDLE->RD1->RD2->WR->RESP.
  - WR drives the captured word with the target lane(s) replaced.
  - Lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1].
- RESP: resp_valid=1 for exactly one cycle, resp_err=0.
  - Loads: lane selected by addr[1:0] (byte) or addr[1] (half), sign/zero-extended to 32 per req_signed.
  - Stores: resp_rdata=0.
- Bus rules:
  - mem_data is driven only when mem_wrEn=1; otherwise it is Z.
  - mem_rdEn and mem_wrEn are never high in the same cycle.
  - mem_addr holds stable across RD1..WR.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP or ERR. No accept occurs in the RESP cycle.
- Reset: at the rst edge the state goes to IDLE and all registered outputs clear:
  - req_ready=1; resp_valid, resp_err, mem_rdEn, mem_wrEn = 0; resp_rdata and mem_addr = 0; bus released.
- Reset mid-operation:
  - If rst is sampled on the edge that ends a WR cycle, that write still commits, because the RAM samples wrEn on the same edge.
  - Otherwise the operation is dropped and no response is generated.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - MEM_BYTES default
- Sub-module lane_align (combinational): given word, addr[1:0], size and signed, produce
  - extended load data, and
  - merged store word from (old word, wdata).
- The FSM and bus control live in mem_access_unit.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10 -> resp in cycle 2 after accept; load @0x10 -> resp_rdata=0xDEADBEEF in cycle 3; checker confirms no bus contention.
- Byte RMW: preload 0x11223344 @0x20; store byte 0xAA @0x22 -> RAM word becomes 0x11AA3344, WR occurs in cycle 3.
- Signed loads: word 0x80F07F01 @0x30; byte load @0x31 signed -> 0x0000007F; @0x32 signed -> 0xFFFFFFF0; half @0x32 unsigned -> 0x000080F0.
- Errors: half @0x41, word @0x42, size=11, word @0x100 -> each gives resp_err=1 one cycle after accept; mem_rdEn and mem_wrEn stay 0 throughout.
- Reset mid-op: assert rst during RD2 of a sub-word store -> next cycle IDLE, req_ready=1, no resp_valid, RAM word unchanged.
- Back-to-back: requests held valid continuously -> req_ready pulses only in IDLE; 4 mixed ops complete in order with correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer: size encodings, FSM states,
// default memory size and the request legality check.
package mem_pkg;

    localparam int unsigned DWIDTH_DEF    = 32;
    localparam int unsigned MEM_BYTES_DEF = 256;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_WR,
        ST_RESP,
        ST_ERR
    } state_t;

    // True when a request must be rejected without touching memory.
    function automatic logic access_error(input logic [1:0] size,
                                          input logic [1:0] addr_lo,
                                          input logic       out_of_range);
        logic err;
        case (size)
            SZ_BYTE: err = out_of_range;
            SZ_HALF: err = out_of_range | addr_lo[0];
            SZ_WORD: err = out_of_range | (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for a 32-bit little-endian word.
//   word         : word read from RAM
//   addr_lo      : byte offset inside the word
//   size/is_signed: access size and load extension mode
//   wdata        : right-justified store data
//   load_data_c  : selected lane, sign/zero extended
//   store_word_c : word with the target lane(s) replaced by wdata (wdata for word size)
module lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF
) (
    input  logic [DWIDTH-1:0] word,
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] load_data_c,
    output logic [DWIDTH-1:0] store_word_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane select, extension and merge; byte lane = addr_lo, half lane = addr_lo[1].
    always_comb begin
        byte_c       = word[{addr_lo, 3'b000} +: 8];
        half_c       = word[{addr_lo[1], 4'b0000} +: 16];
        load_data_c  = word;
        store_word_c = wdata;
        case (size)
            SZ_BYTE: begin
                load_data_c  = {{(DWIDTH-8){is_signed & byte_c[7]}}, byte_c};
                store_word_c = word;
                store_word_c[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data_c  = {{(DWIDTH-16){is_signed & half_c[15]}}, half_c};
                store_word_c = word;
                store_word_c[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a 32-bit word RAM.
//   req_*   : one request at a time, accepted when req_valid && req_ready
//   resp_*  : one-cycle completion pulse with aligned load data or error flag
//   mem_*   : RAM word address, read/write enables and shared tri-state data bus
// Sub-word stores are done as read-modify-write. All outputs are registered:
// their next values are decoded from the next state.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DWIDTH    = DWIDTH_DEF,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DWIDTH-1:0] mem_addr,
    output logic              mem_rdEn,
    output logic              mem_wrEn,
    inout  wire  [DWIDTH-1:0] mem_data
);

    state_t state, next_state;

    logic              accept_c;
    logic              req_err_c;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [1:0]        lo_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] load_data_c;
    logic [DWIDTH-1:0] store_word_c;

    logic              req_ready_d;
    logic              resp_valid_d;
    logic              resp_err_d;
    logic              mem_rdEn_d;
    logic              mem_wrEn_d;
    logic [DWIDTH-1:0] resp_rdata_d;

    assign accept_c  = req_valid && req_ready;
    assign req_err_c = access_error(req_size, req_addr[1:0],
                                    req_addr >= DWIDTH'(MEM_BYTES));

    // Bus is driven only while a write is on it.
    assign mem_data = mem_wrEn ? wdata_q : {DWIDTH{1'bz}};

    lane_align #(.DWIDTH(DWIDTH)) u_lane_align (
        .word         (mem_data),
        .addr_lo      (lo_q),
        .size         (size_q),
        .is_signed    (signed_q),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_rdEn   <= 1'b0;
            mem_wrEn   <= 1'b0;
        end else begin
            state      <= next_state;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_rdEn   <= mem_rdEn_d;
            mem_wrEn   <= mem_wrEn_d;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (req_err_c)                next_state = ST_ERR;
                    else if (!req_we)             next_state = ST_RD1;
                    else if (req_size == SZ_WORD) next_state = ST_WR;
                    else                          next_state = ST_RD1;
                end
            end
            ST_RD1:  next_state = ST_RD2;
            ST_RD2:  next_state = we_q ? ST_WR : ST_RESP;
            ST_WR:   next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output next values; load data is taken off the bus on the RD2 -> RESP edge.
    always_comb begin
        req_ready_d  = (next_state == ST_IDLE);
        resp_valid_d = (next_state == ST_RESP) || (next_state == ST_ERR);
        resp_err_d   = (next_state == ST_ERR);
        mem_rdEn_d   = (next_state == ST_RD1) || (next_state == ST_RD2);
        mem_wrEn_d   = (next_state == ST_WR);
        resp_rdata_d = '0;
        if ((state == ST_RD2) && (next_state == ST_RESP)) begin
            resp_rdata_d = load_data_c;
        end
    end

    // Request capture and RMW merge; mem_addr holds until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SZ_BYTE;
            lo_q     <= 2'b00;
            wdata_q  <= '0;
            mem_addr <= '0;
        end else if (accept_c) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            lo_q     <= req_addr[1:0];
            wdata_q  <= req_wdata;
            mem_addr <= {req_addr[DWIDTH-1:2], 2'b00};
        end else if ((state == ST_RD2) && we_q) begin
            wdata_q  <= store_word_c;
        end
    end

endmodule
